// File: rtl/cache_ctrl_param.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a latency-tolerant line fill.
// Define CACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module cache_ctrl_param #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LINES  = 8,
  parameter int unsigned WORDS  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              hit_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt_o,
  output logic [15:0]       miss_cnt_o
`endif
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W - 1;
  localparam int unsigned CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LastWord = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StWait} state_e;

  state_e                   state_q, state_d;
  logic [TAG_W-1:0]         tag_q [LINES];
  logic [LINES-1:0]         valid_q, valid_d;
  logic [DATA_W-1:0]        data_q [LINES*WORDS];
  logic [TAG_W-1:0]         lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]         lat_idx_q, lat_idx_d;
  logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]         ret_cnt_q, ret_cnt_d;

  logic [OFF_W-1:0]         req_off;
  logic [IDX_W-1:0]         req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic                     hit;
  logic                     store_hit;
  logic                     fill_we;
  logic                     line_done;
  logic                     load_miss;
  logic                     unused_addr_lsb;

  assign req_off         = req_addr_i[OFF_W:1];
  assign req_idx         = req_addr_i[OFF_W+IDX_W:OFF_W+1];
  assign req_tag         = req_addr_i[ADDR_W-1:OFF_W+IDX_W+1];
  assign unused_addr_lsb = req_addr_i[0];

  assign hit       = req_valid_i && (state_q == StIdle) && valid_q[req_idx]
                     && (tag_q[req_idx] == req_tag);
  assign store_hit = hit && req_write_i;
  assign load_miss = req_valid_i && !req_write_i && !hit && (state_q == StIdle);
  // Returns only count while a fill is outstanding; strays after reset land in IDLE.
  assign fill_we   = mem_rvalid_i && (state_q != StIdle);
  assign line_done = fill_we && (ret_cnt_q == LastWord);

  assign hit_o   = hit;
  assign rdata_o = hit ? data_q[{req_idx, req_off}] : '0;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    lat_tag_d   = lat_tag_q;
    lat_idx_d   = lat_idx_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    stall_o     = 1'b0;
    mem_en_o    = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_write_i) begin
          mem_en_o    = 1'b1;
          mem_wr_o    = 1'b1;
          mem_addr_o  = req_addr_i;
          mem_wdata_o = req_wdata_i;
        end else if (load_miss) begin
          stall_o     = 1'b1;
          lat_tag_d   = req_tag;
          lat_idx_d   = req_idx;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = StFill;
        end
      end
      StFill: begin
        stall_o     = 1'b1;
        mem_en_o    = 1'b1;
        mem_addr_o  = {lat_tag_q, lat_idx_q, issue_cnt_q[OFF_W-1:0], 1'b0};
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LastWord) state_d = StWait;
      end
      StWait: begin
        stall_o = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (fill_we) begin
      ret_cnt_d = ret_cnt_q + 1'b1;
      if (line_done) begin
        valid_d[lat_idx_q] = 1'b1;
        state_d            = StIdle;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      lat_tag_q   <= '0;
      lat_idx_q   <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      lat_tag_q   <= lat_tag_d;
      lat_idx_q   <= lat_idx_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  // Tag and data arrays need no reset: the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (store_hit) data_q[{req_idx, req_off}] <= req_wdata_i;
    if (fill_we) data_q[{lat_idx_q, ret_cnt_q[OFF_W-1:0]}] <= mem_rdata_i;
    if (line_done) tag_q[lat_idx_q] <= lat_tag_q;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
    if (load_miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Directed bench for cache_ctrl_param: latency-4 memory model (word = address unless written),
// scoreboard queues for expected read issues and write-through pulses.
module tb_cache_ctrl_param;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] rdata;
  logic        hit;
  logic        stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_ctrl_param #(
    .ADDR_W(16),
    .DATA_W(16),
    .LINES (8),
    .WORDS (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rdata_o     (rdata),
    .hit_o       (hit),
    .stall_o     (stall),
    .mem_en_o    (mem_en),
    .mem_wr_o    (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_rvalid_i(mem_rvalid)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic        pv [L];
  logic [15:0] pa [L];
  logic [15:0] exp_rd_q [$];
  logic [31:0] exp_wr_q [$];
  logic [15:0] mem_ovr [logic [15:0]];

  logic        o_stall, o_hit, o_mem_en;
  logic [15:0] o_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return mem_ovr.exists(a) ? mem_ovr[a] : a;
  endfunction

  // One clock cycle: sample outputs, score memory traffic, advance the memory pipe.
  task automatic tick();
    logic        new_v;
    logic [15:0] new_a;
    #1;
    o_stall  = stall;
    o_hit    = hit;
    o_rdata  = rdata;
    o_mem_en = mem_en;
    new_v    = mem_en && !mem_wr;
    new_a    = mem_addr;
    if (mem_en && !mem_wr) begin
      if (exp_rd_q.size() == 0) check("issue_extra", 32'(exp_rd_q.size()), 32'd1);
      else check("issue_addr", {16'h0, mem_addr}, {16'h0, exp_rd_q.pop_front()});
    end
    if (mem_en && mem_wr) begin
      if (exp_wr_q.size() == 0) check("write_extra", 32'(exp_wr_q.size()), 32'd1);
      else check("write_addr_data", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
      mem_ovr[mem_addr] = mem_wdata;
    end
    @(posedge clk);
    #1;
    for (int i = L - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0]      = new_v;
    pa[0]      = new_a;
    mem_rvalid = pv[L-1];
    mem_rdata  = pv[L-1] ? mem_read(pa[L-1]) : 16'h0;
  endtask

  task automatic load_miss(input logic [15:0] a, input logic [15:0] exp, input string tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    for (int k = 0; k < 8; k++) exp_rd_q.push_back({a[15:4], 4'h0} + 16'(2 * k));
    tick();
    check({tag, "_detect_stall_hit"}, {30'h0, o_stall, o_hit}, 32'h2);
    n = 1;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (o_stall) n++;
      else done = 1'b1;
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd13);
    check({tag, "_replay_hit"}, {31'h0, o_hit}, 32'h1);
    check({tag, "_replay_rdata"}, {16'h0, o_rdata}, {16'h0, exp});
    check({tag, "_issues_left"}, 32'(exp_rd_q.size()), 32'd0);
  endtask

  task automatic load_hit(input logic [15:0] a, input logic [15:0] exp, input string tag);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    tick();
    check({tag, "_stall_hit"}, {30'h0, o_stall, o_hit}, 32'h1);
    check({tag, "_rdata"}, {16'h0, o_rdata}, {16'h0, exp});
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, input logic exp_hit,
                       input string tag);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    exp_wr_q.push_back({a, d});
    tick();
    check({tag, "_stall_hit"}, {30'h0, o_stall, o_hit}, {30'h0, 1'b0, exp_hit});
    check({tag, "_write_seen"}, 32'(exp_wr_q.size()), 32'd0);
    req_valid = 1'b0;
    req_write = 1'b0;
    tick();
    check({tag, "_pulse_len"}, {31'h0, o_mem_en}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < L; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0;
    end
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 16'h0;
    req_wdata  = 16'h0;
    mem_rdata  = 16'h0;
    mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    req_addr = 16'h0010;
    tick();
    check("reset_stall_hit_en", {29'h0, o_stall, o_hit, o_mem_en}, 32'h0);
    check("reset_rdata", {16'h0, o_rdata}, 32'h0);

    load_miss(16'h0010, 16'h0010, "fill_0010");
    load_hit(16'h0012, 16'h0012, "hit_0012");
    load_hit(16'h001E, 16'h001E, "hit_001e");
    store(16'h0014, 16'hBEEF, 1'b1, "store_hit_0014");
    load_hit(16'h0014, 16'hBEEF, "hit_0014_new");
    store(16'h0100, 16'h1234, 1'b0, "store_miss_0100");
    load_miss(16'h0100, 16'h1234, "fill_0100");
    load_hit(16'h0010, 16'h0010, "line1_intact");

    load_miss(16'h0090, 16'h0090, "conflict_0090");
    load_miss(16'h0010, 16'h0010, "conflict_0010");
    load_hit(16'h0014, 16'hBEEF, "writethrough_0014");
    load_miss(16'h0090, 16'h0090, "conflict_0090b");

    // Reset while the fill is issuing word 3.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0010;
    for (int k = 0; k < 8; k++) exp_rd_q.push_back(16'h0010 + 16'(2 * k));
    tick();
    check("midrst_detect", {31'h0, o_stall}, 32'h1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    exp_rd_q.delete();
    tick();
    check("midrst_after_stall_en", {30'h0, o_stall, o_mem_en}, 32'h0);
    for (int i = 0; i < L + 2; i++) tick();
    check("midrst_idle_stall", {31'h0, o_stall}, 32'h0);
    load_miss(16'h0010, 16'h0010, "midrst_refill");
    load_miss(16'h0100, 16'h1234, "midrst_all_invalid");

    req_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
